// File: rtl/seg7_scan_mux.sv
// Time-multiplexed 7-segment scanner with per-slot PWM brightness.
// One digit is shown per slot. Every output is registered.
module seg7_scan_mux #(
    parameter int NUM_DIGITS = 8,
    parameter int SEG_W      = 8,
    parameter int TICK_DIV   = 6250,
    parameter int DIM_BITS   = 4,
    localparam int IDX_W     = $clog2(NUM_DIGITS),
    localparam int TICK_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1
) (
    input  logic                        i_sclk,
    input  logic                        i_reset,
    input  logic [NUM_DIGITS*SEG_W-1:0] i_seg_data,
    input  logic [NUM_DIGITS-1:0]       i_digit_en,
    input  logic [DIM_BITS-1:0]         i_bright,
    input  logic                        i_blank,
    output logic [SEG_W-1:0]            o_segments,
    output logic [NUM_DIGITS-1:0]       o_digits,
    output logic [IDX_W-1:0]            o_scan_idx,
    output logic                        o_frame_done
);

    logic [TICK_W-1:0]     tick_q, tick_d;
    logic [DIM_BITS-1:0]   sub_q, sub_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [SEG_W-1:0]      pat_q, pat_d;
    logic [DIM_BITS-1:0]   bright_q, bright_d;
    logic                  valid_q, valid_d;
    logic                  first_q, first_d;
    logic [SEG_W-1:0]      seg_q, seg_d;
    logic [NUM_DIGITS-1:0] dig_q, dig_d;
    logic                  fd_q, fd_d;

    logic                  tick, slot_start, found, on;
    logic [IDX_W-1:0]      nxt_idx, cand;

    always_comb begin
        tick       = (tick_q == TICK_W'(TICK_DIV - 1));
        slot_start = tick && (sub_q == {DIM_BITS{1'b1}});
        tick_d     = tick ? '0 : tick_q + 1'b1;
        sub_d      = tick ? sub_q + 1'b1 : sub_q;

        // Ascending search from idx+1; k = NUM_DIGITS lands back on the current digit.
        nxt_idx = idx_q;
        found   = 1'b0;
        cand    = '0;
        for (int k = 1; k <= NUM_DIGITS; k++) begin
            cand = IDX_W'((int'(idx_q) + k) % NUM_DIGITS);
            if (!found && i_digit_en[cand]) begin
                found   = 1'b1;
                nxt_idx = cand;
            end
        end

        idx_d    = idx_q;
        pat_d    = pat_q;
        bright_d = bright_q;
        valid_d  = valid_q;
        first_d  = first_q;
        fd_d     = 1'b0;
        if (slot_start) begin
            first_d = 1'b0;
            valid_d = found;
            if (found) begin
                idx_d    = nxt_idx;
                pat_d    = i_seg_data[nxt_idx*SEG_W +: SEG_W];
                bright_d = i_bright;
                fd_d     = !first_q && (nxt_idx <= idx_q);
            end
        end

        // Outputs are computed from next state so they move on the same edge.
        on    = valid_d && !i_blank && (sub_d <= bright_d);
        dig_d = on ? ~(NUM_DIGITS'(1) << idx_d) : '1;
        seg_d = on ? pat_d : '1;
    end

    // Counters rest at terminal values so the first edge after reset starts a slot.
    always_ff @(posedge i_sclk or posedge i_reset) begin
        if (i_reset) begin
            tick_q   <= TICK_W'(TICK_DIV - 1);
            sub_q    <= '1;
            idx_q    <= IDX_W'(NUM_DIGITS - 1);
            pat_q    <= '1;
            bright_q <= '0;
            valid_q  <= 1'b0;
            first_q  <= 1'b1;
            seg_q    <= '1;
            dig_q    <= '1;
            fd_q     <= 1'b0;
        end else begin
            tick_q   <= tick_d;
            sub_q    <= sub_d;
            idx_q    <= idx_d;
            pat_q    <= pat_d;
            bright_q <= bright_d;
            valid_q  <= valid_d;
            first_q  <= first_d;
            seg_q    <= seg_d;
            dig_q    <= dig_d;
            fd_q     <= fd_d;
        end
    end

    assign o_segments   = seg_q;
    assign o_digits     = dig_q;
    assign o_scan_idx   = idx_q;
    assign o_frame_done = fd_q;

endmodule
